vc_tx_arbiter: RTL and testbench
================================

# vc_tx_arbiter

Transmit-side arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the PCI transmission layer. It pops words from VC0/VC1 under weighted round-robin and routes each word to D0 or D1 by its MSB. It stalls on destination back-pressure. It also sequences bring-up: it latches the FIFO thresholds during init and drives them to every FIFO.

## Interface
- DATA_WIDTH, 6: word width, identical on all FIFOs
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state RESET
- init  in  1  1 = enter/hold INIT and latch configuration
- umbral_vc_in  in  4  almost-empty/almost-full threshold for VC FIFOs
- umbral_d_in  in  4  threshold for D FIFOs; legal range 2..15
- weight_vc0_in, weight_vc1_in  in  3 each  grants per turn; 0 treated as 1
- empty_fifo_VC0, empty_fifo_VC1  in  1 each  source FIFO empty flags
- data_out_VC0, data_out_VC1  in  DATA_WIDTH each  source FIFO read data (valid the cycle after rd_enable)
- almost_full_fifo_D0, almost_full_fifo_D1  in  1 each  destination back-pressure
- full_fifo_D0, full_fifo_D1  in  1 each  destination full flags
- rd_enable_VC0, rd_enable_VC1  out  1 each  pop strobes, one-hot or zero
- wr_enable_D0, wr_enable_D1  out  1 each  push strobes, one-hot or zero
- data_out_D  out  DATA_WIDTH  word pushed to the selected destination; 0 when no push
- Umbral_VC, Umbral_D  out  4 each  registered thresholds to the FIFOs
- state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
- idle_out, active_out  out  1 each  decodes of state
- error_out  out  1  sticky; set when a push targets a full destination

## Operation
- Reset (reset=1 at an edge) sets the following:
  - state=RESET.
  - All strobes 0, data_out_D=0, Umbral_VC=Umbral_D=0, error_out=0.
  - Credit counter 0, current VC=VC0, pending-pop register invalid.
- State transitions:
  - RESET to INIT on the first edge with reset=0.
  - INIT: every cycle with init=1, Umbral_VC<=umbral_vc_in, Umbral_D<=umbral_d_in, weights latched. No pops. Go to IDLE when init=0.
  - IDLE to ACTIVE when either empty flag is 0. Pops may start in the ACTIVE cycle itself, not in IDLE.
  - ACTIVE to IDLE when both empty flags are 1, no pop is issued this cycle and no pop is pending.
  - IDLE or ACTIVE to INIT when init=1. An already-pending pop still completes its push. No new pops are issued.
- Pop eligibility (ACTIVE only): almost_full_fifo_D0=0 and almost_full_fifo_D1=0. At most one pop per cycle.
- Weighted round-robin:
  - If the current VC is non-empty and credit>0, pop it and decrement credit.
  - Otherwise, if the other VC is non-empty, switch to it, load credit=weight-1 and pop it.
  - Otherwise, if the current VC is non-empty, reload credit=weight-1 and pop it.
  - Otherwise, no pop.
- Push stage: the pending register holds {valid, vc}.
  - The cycle after a pop, data_out_D = data_out_VCx of the popped VC.
  - data_out_D[DATA_WIDTH-1]=0 asserts wr_enable_D0; =1 asserts wr_enable_D1.
- Error: if the selected full_fifo_Dx=1 during a push, the push is still driven and error_out is set. error_out clears only on reset.
- Back-pressure during a pending pop: the pending push always completes. Back-pressure only blocks new pops. umbral_d ≥ 2 guarantees room for the one in-flight word.

## Timing
- Pop at edge t is followed by wr_enable_Dx and data_out_D valid for exactly cycle t+1. This is a combinational path from the pending register and the FIFO data.
- Sustained throughput is 1 word/cycle. A pop in cycle t and a push of the previous word occur concurrently.
- Empty flags are sampled the same cycle as the pop decision. A FIFO holding 1 word gets exactly one pop.
- Threshold outputs are registered and change one cycle after the init cycle that latched them.
- Reset mid-operation drops the pending word: no push in the cycle after reset.

## Test plan
- Bring-up:
  - Stimulus: reset 2 cycles, init=1 for 3 cycles with umbral_vc_in=3, umbral_d_in=4, then init=0.
  - Required: state 0→1→2, Umbral_VC=3, Umbral_D=4, no strobes at any point.
- Weights:
  - Stimulus: weights 3/1, both VCs preloaded with 8 words, destinations never almost full.
  - Required: pop order VC0,VC0,VC0,VC1 repeating. Each wr_enable follows its pop by 1 cycle with matching data.
- Routing:
  - Stimulus: VC1 words 6'h05, 6'h25, 6'h3F.
  - Required: wr_enable_D0 with data 05, then wr_enable_D1 with data 25, then wr_enable_D1 with data 3F.
- Back-pressure:
  - Stimulus: almost_full_fifo_D1=1 raised on the cycle after a pop.
  - Required: the pending push completes, no further pops, and popping resumes the cycle the flag drops.
- Drain/idle:
  - Stimulus: VC0 holds 1 word, VC1 empty.
  - Required: exactly one rd_enable_VC0, one push, then state returns to IDLE.
- Error/reset:
  - Stimulus: a push to D0 while full_fifo_D0=1, then reset asserted the cycle after a pop.
  - Required: error_out=1 after the full-destination push and stays set until reset. No push in the cycle after reset, and all outputs are 0.

Source files
------------

// File: rtl/vc_tx_arbiter_if.sv
// vc_tx_arbiter_if: VC source FIFO, destination FIFO and configuration signals of the tx arbiter
interface vc_tx_arbiter_if #(parameter int DATA_WIDTH = 6);
    logic                  init;
    logic [3:0]            umbral_vc_in;
    logic [3:0]            umbral_d_in;
    logic [2:0]            weight_vc0_in;
    logic [2:0]            weight_vc1_in;
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [DATA_WIDTH-1:0] data_out_VC0;
    logic [DATA_WIDTH-1:0] data_out_VC1;
    logic                  almost_full_fifo_D0;
    logic                  almost_full_fifo_D1;
    logic                  full_fifo_D0;
    logic                  full_fifo_D1;
    logic                  rd_enable_VC0;
    logic                  rd_enable_VC1;
    logic                  wr_enable_D0;
    logic                  wr_enable_D1;
    logic [DATA_WIDTH-1:0] data_out_D;
    logic [3:0]            Umbral_VC;
    logic [3:0]            Umbral_D;
    logic [1:0]            state;
    logic                  idle_out;
    logic                  active_out;
    logic                  error_out;

    modport master (
        input  init, umbral_vc_in, umbral_d_in, weight_vc0_in, weight_vc1_in,
               empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
               almost_full_fifo_D0, almost_full_fifo_D1, full_fifo_D0, full_fifo_D1,
        output rd_enable_VC0, rd_enable_VC1, wr_enable_D0, wr_enable_D1, data_out_D,
               Umbral_VC, Umbral_D, state, idle_out, active_out, error_out
    );

    modport slave (
        output init, umbral_vc_in, umbral_d_in, weight_vc0_in, weight_vc1_in,
               empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
               almost_full_fifo_D0, almost_full_fifo_D1, full_fifo_D0, full_fifo_D1,
        input  rd_enable_VC0, rd_enable_VC1, wr_enable_D0, wr_enable_D1, data_out_D,
               Umbral_VC, Umbral_D, state, idle_out, active_out, error_out
    );
endinterface

// File: rtl/vc_tx_arbiter.sv
// vc_tx_arbiter: weighted round-robin pop from VC0/VC1, MSB-routed push to D0/D1, bring-up sequencing
module vc_tx_arbiter #(
    parameter int DATA_WIDTH = 6
) (
    input logic                clk,
    input logic                reset,
    vc_tx_arbiter_if.master    bus
);
    typedef enum logic [1:0] {RESET = 2'd0, INIT = 2'd1, IDLE = 2'd2, ACTIVE = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [3:0]            umbral_vc_q, umbral_vc_d, umbral_d_q, umbral_d_d;
    logic [2:0]            w0_q, w0_d, w1_q, w1_d, credit_q, credit_d;
    logic                  cur_q, cur_d, pend_v_q, pend_v_d, pend_vc_q, pend_vc_d, err_q, err_d;
    logic                  e_cur, e_oth, can_pop, pop, pop_vc, latch, both_empty;
    logic [2:0]            w_cur, w_oth;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [2:0] reload(input logic [2:0] w);
        return (w == 3'd0) ? 3'd0 : w - 3'd1;
    endfunction

    always_comb begin
        e_cur      = cur_q ? bus.empty_fifo_VC1 : bus.empty_fifo_VC0;
        e_oth      = cur_q ? bus.empty_fifo_VC0 : bus.empty_fifo_VC1;
        w_cur      = cur_q ? w1_q : w0_q;
        w_oth      = cur_q ? w0_q : w1_q;
        both_empty = bus.empty_fifo_VC0 & bus.empty_fifo_VC1;
        can_pop    = (state_q == ACTIVE) & ~bus.init & ~bus.almost_full_fifo_D0 & ~bus.almost_full_fifo_D1;
        pop        = 1'b0;
        pop_vc     = cur_q;
        cur_d      = cur_q;
        credit_d   = credit_q;
        if (can_pop) begin
            if (!e_cur && credit_q != 3'd0) begin
                pop      = 1'b1;
                credit_d = credit_q - 3'd1;
            end else if (!e_oth) begin
                pop      = 1'b1;
                pop_vc   = ~cur_q;
                cur_d    = ~cur_q;
                credit_d = reload(w_oth);
            end else if (!e_cur) begin
                pop      = 1'b1;
                credit_d = reload(w_cur);
            end
        end
        pend_v_d  = pop;
        pend_vc_d = pop_vc;
        // The pushed word comes straight from the source FIFO output, one cycle after its pop.
        push_data = pend_v_q ? (pend_vc_q ? bus.data_out_VC1 : bus.data_out_VC0) : '0;
        err_d     = err_q
                  | (pend_v_q & ~push_data[DATA_WIDTH-1] & bus.full_fifo_D0)
                  | (pend_v_q &  push_data[DATA_WIDTH-1] & bus.full_fifo_D1);
        latch       = (state_q == INIT) & bus.init;
        umbral_vc_d = latch ? bus.umbral_vc_in  : umbral_vc_q;
        umbral_d_d  = latch ? bus.umbral_d_in   : umbral_d_q;
        w0_d        = latch ? bus.weight_vc0_in : w0_q;
        w1_d        = latch ? bus.weight_vc1_in : w1_q;
        state_d = state_q;
        case (state_q)
            RESET:   state_d = INIT;
            INIT:    state_d = bus.init ? INIT : IDLE;
            IDLE:    state_d = bus.init ? INIT : (both_empty ? IDLE : ACTIVE);
            ACTIVE:  state_d = bus.init ? INIT : ((both_empty && !pop && !pend_v_q) ? IDLE : ACTIVE);
            default: state_d = RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET;
            umbral_vc_q <= '0;
            umbral_d_q  <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            credit_q    <= '0;
            cur_q       <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_vc_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            umbral_vc_q <= umbral_vc_d;
            umbral_d_q  <= umbral_d_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            credit_q    <= credit_d;
            cur_q       <= cur_d;
            pend_v_q    <= pend_v_d;
            pend_vc_q   <= pend_vc_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd_enable_VC0 = pop & ~pop_vc;
    assign bus.rd_enable_VC1 = pop &  pop_vc;
    assign bus.wr_enable_D0  = pend_v_q & ~push_data[DATA_WIDTH-1];
    assign bus.wr_enable_D1  = pend_v_q &  push_data[DATA_WIDTH-1];
    assign bus.data_out_D    = push_data;
    assign bus.Umbral_VC     = umbral_vc_q;
    assign bus.Umbral_D      = umbral_d_q;
    assign bus.state         = state_q;
    assign bus.idle_out      = (state_q == IDLE);
    assign bus.active_out    = (state_q == ACTIVE);
    assign bus.error_out     = err_q;
endmodule

// File: tb/tb_vc_tx_arbiter.sv
// tb_vc_tx_arbiter: directed bring-up/weight/routing/back-pressure/drain/error phases plus random traffic vs a reference model
module tb_vc_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    vc_tx_arbiter_if #(.DATA_WIDTH(6)) bus ();
    vc_tx_arbiter #(.DATA_WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [5:0] q0[$], q1[$];
    int         m_st, m_cred, m_w0, m_w1;
    bit         m_cur, m_pv, m_err;
    logic [5:0] m_pw;
    logic [3:0] m_uvc, m_ud;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rl(input int w);
        return (w == 0) ? 0 : w - 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cred = 0; m_w0 = 0; m_w1 = 0;
        m_cur = 0; m_pv = 0; m_err = 0; m_pw = '0;
        m_uvc = '0; m_ud = '0;
    endtask

    // One clock: predict this cycle's outputs from the rules, compare, then advance the model and the source FIFOs.
    task automatic tick();
        int         pop, ncred, nst;
        bit         e0, e1, ec, eo, ncur, rd0, rd1;
        logic [5:0] pw;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        bus.empty_fifo_VC0 = e0;
        bus.empty_fifo_VC1 = e1;
        #1;
        pop = -1; ncur = m_cur; ncred = m_cred; pw = '0;
        if (m_st == 3 && !bus.init && !bus.almost_full_fifo_D0 && !bus.almost_full_fifo_D1) begin
            ec = m_cur ? e1 : e0;
            eo = m_cur ? e0 : e1;
            if (!ec && m_cred > 0) begin
                pop = int'(m_cur); ncred = m_cred - 1;
            end else if (!eo) begin
                pop = int'(!m_cur); ncur = !m_cur; ncred = rl(m_cur ? m_w0 : m_w1);
            end else if (!ec) begin
                pop = int'(m_cur); ncred = rl(m_cur ? m_w1 : m_w0);
            end
        end
        check("rd_vc0", 32'(bus.rd_enable_VC0), 32'(pop == 0));
        check("rd_vc1", 32'(bus.rd_enable_VC1), 32'(pop == 1));
        check("wr_d0", 32'(bus.wr_enable_D0), 32'(m_pv && !m_pw[5]));
        check("wr_d1", 32'(bus.wr_enable_D1), 32'(m_pv && m_pw[5]));
        check("data_d", 32'(bus.data_out_D), m_pv ? 32'(m_pw) : 32'd0);
        check("state", 32'(bus.state), 32'(m_st));
        check("idle", 32'(bus.idle_out), 32'(m_st == 2));
        check("active", 32'(bus.active_out), 32'(m_st == 3));
        check("error", 32'(bus.error_out), 32'(m_err));
        check("umbral_vc", 32'(bus.Umbral_VC), 32'(m_uvc));
        check("umbral_d", 32'(bus.Umbral_D), 32'(m_ud));
        rd0 = bus.rd_enable_VC0;
        rd1 = bus.rd_enable_VC1;
        if (pop == 0) pw = q0[0];
        if (pop == 1) pw = q1[0];
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_pv && ((!m_pw[5] && bus.full_fifo_D0) || (m_pw[5] && bus.full_fifo_D1))) m_err = 1;
            case (m_st)
                0: nst = 1;
                1: nst = bus.init ? 1 : 2;
                2: nst = bus.init ? 1 : ((e0 && e1) ? 2 : 3);
                default: nst = bus.init ? 1 : ((e0 && e1 && pop < 0 && !m_pv) ? 2 : 3);
            endcase
            if (m_st == 1 && bus.init) begin
                m_uvc = bus.umbral_vc_in; m_ud = bus.umbral_d_in;
                m_w0 = int'(bus.weight_vc0_in); m_w1 = int'(bus.weight_vc1_in);
            end
            m_pv = (pop >= 0); m_pw = pw; m_cur = ncur; m_cred = ncred; m_st = nst;
        end
        #1;
        if (rd0 && q0.size() > 0) bus.data_out_VC0 = q0.pop_front();
        if (rd1 && q1.size() > 0) bus.data_out_VC1 = q1.pop_front();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_pv || m_st != 2) && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_bound", 32'(guard < 200), 32'd1);
    endtask

    task automatic bring_up(input logic [3:0] uvc, input logic [3:0] ud, input logic [2:0] w0, input logic [2:0] w1);
        reset = 1'b1; bus.init = 1'b0;
        run(2);
        reset = 1'b0; bus.init = 1'b1;
        bus.umbral_vc_in = uvc; bus.umbral_d_in = ud;
        bus.weight_vc0_in = w0; bus.weight_vc1_in = w1;
        run(3);
        bus.init = 1'b0;
        run(2);
    endtask

    initial begin
        int init_left;
        bus.init = 0; bus.umbral_vc_in = 0; bus.umbral_d_in = 0;
        bus.weight_vc0_in = 0; bus.weight_vc1_in = 0;
        bus.empty_fifo_VC0 = 1; bus.empty_fifo_VC1 = 1;
        bus.data_out_VC0 = 0; bus.data_out_VC1 = 0;
        bus.almost_full_fifo_D0 = 0; bus.almost_full_fifo_D1 = 0;
        bus.full_fifo_D0 = 0; bus.full_fifo_D1 = 0;
        model_reset();
        bring_up(4'd3, 4'd4, 3'd3, 3'd1);
        check("bringup_uvc", 32'(bus.Umbral_VC), 32'd3);
        check("bringup_ud", 32'(bus.Umbral_D), 32'd4);
        check("bringup_idle", 32'(bus.state), 32'd2);
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'($urandom));
            q1.push_back(6'($urandom));
        end
        drain();
        q1.push_back(6'h05); q1.push_back(6'h25); q1.push_back(6'h3F);
        drain();
        for (int i = 0; i < 6; i++) q0.push_back(6'($urandom));
        run(2);
        bus.almost_full_fifo_D1 = 1'b1;
        run(4);
        bus.almost_full_fifo_D1 = 1'b0;
        drain();
        q0.push_back(6'h11);
        drain();
        bus.full_fifo_D0 = 1'b1;
        q0.push_back(6'h0A);
        run(4);
        check("error_set", 32'(bus.error_out), 32'd1);
        bus.full_fifo_D0 = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back(6'($urandom));
        run(3);
        check("error_sticky", 32'(bus.error_out), 32'd1);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("rst_no_wr", 32'({bus.wr_enable_D0, bus.wr_enable_D1}), 32'd0);
        check("rst_err", 32'(bus.error_out), 32'd0);
        run(1);
        q0.delete(); q1.delete();
        bring_up(4'($urandom), 4'($urandom_range(2, 15)), 3'($urandom), 3'($urandom));
        init_left = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (init_left == 0 && $urandom_range(0, 59) == 0) begin
                init_left = $urandom_range(1, 4);
                bus.umbral_vc_in = 4'($urandom);
                bus.umbral_d_in = 4'($urandom_range(2, 15));
                bus.weight_vc0_in = 3'($urandom);
                bus.weight_vc1_in = 3'($urandom);
            end
            bus.init = (init_left > 0);
            if (init_left > 0) init_left--;
            bus.almost_full_fifo_D0 = ($urandom_range(0, 5) == 0);
            bus.almost_full_fifo_D1 = ($urandom_range(0, 5) == 0);
            bus.full_fifo_D0 = ($urandom_range(0, 9) == 0);
            bus.full_fifo_D1 = ($urandom_range(0, 9) == 0);
            if (q0.size() < 16 && $urandom_range(0, 2) == 0) q0.push_back(6'($urandom));
            if (q1.size() < 16 && $urandom_range(0, 2) == 0) q1.push_back(6'($urandom));
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
